// File: rtl/rf_ctrl_pkg.sv
// Shared widths, request entry type and register-address helpers
// for the banked register-file request arbiter.
package rf_ctrl_pkg;

    localparam int NUM_BANKS = 4;
    localparam int DEPTH     = 4;
    localparam int REG_AW    = 5;
    localparam int OCID_W    = 2;

    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int ROW_W  = REG_AW - BANK_W;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int OCC_W  = PTR_W + 1;

    typedef struct packed {
        logic [OCID_W-1:0] ocid;
        logic              slot;
        logic [ROW_W-1:0]  row;
    } rf_req_t;

    function automatic logic [BANK_W-1:0] bank_of(
        input logic [REG_AW-1:0] r
    );
        return r[BANK_W-1:0];
    endfunction

    function automatic logic [ROW_W-1:0] row_of(
        input logic [REG_AW-1:0] r
    );
        return r[REG_AW-1:BANK_W];
    endfunction

endpackage

// File: rtl/rf_bank_fifo.sv
// Per-bank request FIFO: up to two pushes and one pop per cycle.
// Ports: clk/rst, flush, push_cnt (0..2) with push_d0/push_d1
// (d0 written first), pop, head entry, occupancy and empty flag.
module rf_bank_fifo
    import rf_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [1:0]       push_cnt,
    input  rf_req_t          push_d0,
    input  rf_req_t          push_d1,
    input  logic             pop,
    output rf_req_t          head,
    output logic [OCC_W-1:0] occ,
    output logic             empty
);

    rf_req_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] wr_nxt;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ_q;

    assign wr_nxt = wr_ptr + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ_q  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(push_cnt);
            rd_ptr <= rd_ptr + PTR_W'(pop);
            occ_q  <= occ_q + OCC_W'(push_cnt) - OCC_W'(pop);
        end
    end

    // Storage needs no reset: pointers and occupancy gate every read.
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            if (push_cnt != 2'd0)
                mem[wr_ptr] <= push_d0;
            if (push_cnt == 2'd2)
                mem[wr_nxt] <= push_d1;
        end
    end

    assign head  = mem[rd_ptr];
    assign occ   = occ_q;
    assign empty = (occ_q == '0);

    always_ff @(posedge clk) begin
        if (!rst)
            assert (occ_q <= OCC_W'(DEPTH));
    end

endmodule

// File: rtl/rf_bank_req_arbiter.sv
// Steers operand reads into per-bank FIFOs and issues one access per
// bank per cycle; a CDB writeback owns its bank port for that cycle.
// Ports: req_* handshake from the operand collectors, flush, wb_en/wb_reg,
// registered rf_rd_*/rf_wr_* bank strobes, per-bank occupancy bank_occ.
module rf_bank_req_arbiter
    import rf_ctrl_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_use_a,
    input  logic                          req_use_b,
    input  logic [REG_AW-1:0]             req_reg_a,
    input  logic [REG_AW-1:0]             req_reg_b,
    input  logic [OCID_W-1:0]             req_ocid,
    input  logic                          flush,
    input  logic                          wb_en,
    input  logic [REG_AW-1:0]             wb_reg,
    output logic [NUM_BANKS-1:0]          rf_rd_valid,
    output logic [NUM_BANKS*ROW_W-1:0]    rf_rd_row,
    output logic [NUM_BANKS*OCID_W-1:0]   rf_rd_ocid,
    output logic [NUM_BANKS-1:0]          rf_rd_slot,
    output logic [NUM_BANKS-1:0]          rf_wr_en,
    output logic [ROW_W-1:0]              rf_wr_row,
    output logic [NUM_BANKS*OCC_W-1:0]    bank_occ
);

    localparam int SUM_W = OCC_W + 1;

    rf_req_t               ent_a;
    rf_req_t               ent_b;
    logic [BANK_W-1:0]     bank_a;
    logic [BANK_W-1:0]     bank_b;
    logic [BANK_W-1:0]     bank_wb;
    logic                  accept;

    logic [NUM_BANKS-1:0]  hit_a;
    logic [NUM_BANKS-1:0]  hit_b;
    logic [NUM_BANKS-1:0]  fits;
    logic [NUM_BANKS-1:0]  wb_hit;
    logic [NUM_BANKS-1:0]  pop;
    logic [NUM_BANKS-1:0]  empty;
    logic [1:0]            need     [NUM_BANKS];
    logic [1:0]            push_cnt [NUM_BANKS];
    logic [OCC_W-1:0]      occ      [NUM_BANKS];
    rf_req_t               d0       [NUM_BANKS];
    rf_req_t               head     [NUM_BANKS];

    logic [NUM_BANKS-1:0]  rd_vld_q;
    logic [NUM_BANKS-1:0]  rd_slot_q;
    logic [ROW_W-1:0]      rd_row_q  [NUM_BANKS];
    logic [OCID_W-1:0]     rd_ocid_q [NUM_BANKS];
    logic [NUM_BANKS-1:0]  wr_en_q;
    logic [ROW_W-1:0]      wr_row_q;

    assign bank_a  = bank_of(req_reg_a);
    assign bank_b  = bank_of(req_reg_b);
    assign bank_wb = bank_of(wb_reg);

    assign ent_a = '{ocid: req_ocid, slot: 1'b0, row: row_of(req_reg_a)};
    assign ent_b = '{ocid: req_ocid, slot: 1'b1, row: row_of(req_reg_b)};

    // Space is judged on current occupancy only; a pop this cycle
    // does not make room for a push this cycle.
    assign req_ready = !flush && (&fits);
    assign accept    = req_valid && req_ready;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        assign hit_a[b] = req_use_a && (bank_a == BANK_W'(b));
        assign hit_b[b] = req_use_b && (bank_b == BANK_W'(b));
        assign need[b]  = {1'b0, hit_a[b]} + {1'b0, hit_b[b]};
        assign fits[b]  = (SUM_W'(occ[b]) + SUM_W'(need[b]))
                          <= SUM_W'(DEPTH);

        // A goes first when both operands share the bank.
        assign d0[b]       = hit_a[b] ? ent_a : ent_b;
        assign push_cnt[b] = accept ? need[b] : 2'd0;

        assign wb_hit[b] = wb_en && (bank_wb == BANK_W'(b));
        assign pop[b]    = !wb_hit[b] && !empty[b] && !flush;

        rf_bank_fifo u_fifo (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .push_cnt (push_cnt[b]),
            .push_d0  (d0[b]),
            .push_d1  (ent_b),
            .pop      (pop[b]),
            .head     (head[b]),
            .occ      (occ[b]),
            .empty    (empty[b])
        );

        assign rf_rd_row[b*ROW_W +: ROW_W]    = rd_row_q[b];
        assign rf_rd_ocid[b*OCID_W +: OCID_W] = rd_ocid_q[b];
        assign bank_occ[b*OCC_W +: OCC_W]     = occ[b];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_q  <= '0;
            rd_slot_q <= '0;
            wr_en_q   <= '0;
            wr_row_q  <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                rd_row_q[b]  <= '0;
                rd_ocid_q[b] <= '0;
            end
        end else begin
            rd_vld_q <= pop;
            wr_en_q  <= wb_hit;
            if (wb_en)
                wr_row_q <= row_of(wb_reg);
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (pop[b]) begin
                    rd_row_q[b]  <= head[b].row;
                    rd_ocid_q[b] <= head[b].ocid;
                    rd_slot_q[b] <= head[b].slot;
                end
            end
        end
    end

    assign rf_rd_valid = rd_vld_q;
    assign rf_rd_slot  = rd_slot_q;
    assign rf_wr_en    = wr_en_q;
    assign rf_wr_row   = wr_row_q;

endmodule

// File: tb/tb_rf_bank_req_arbiter.sv
// Directed scoreboard bench for rf_bank_req_arbiter: per-bank expected
// read queues and a writeback queue, drained by a negedge monitor.
module tb_rf_bank_req_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_use_a;
    logic        req_use_b;
    logic [4:0]  req_reg_a;
    logic [4:0]  req_reg_b;
    logic [1:0]  req_ocid;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [3:0]  rf_rd_valid;
    logic [11:0] rf_rd_row;
    logic [7:0]  rf_rd_ocid;
    logic [3:0]  rf_rd_slot;
    logic [3:0]  rf_wr_en;
    logic [2:0]  rf_wr_row;
    logic [11:0] bank_occ;

    int tests = 0;
    int fails = 0;

    // {row, ocid, slot}
    logic [5:0] exp_q [4][$];
    // {mask, row}
    logic [6:0] wr_q [$];
    logic [5:0] e_rd;
    logic [6:0] e_wr;

    always #5 clk = ~clk;

    rf_bank_req_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_use_a   (req_use_a),
        .req_use_b   (req_use_b),
        .req_reg_a   (req_reg_a),
        .req_reg_b   (req_reg_b),
        .req_ocid    (req_ocid),
        .flush       (flush),
        .wb_en       (wb_en),
        .wb_reg      (wb_reg),
        .rf_rd_valid (rf_rd_valid),
        .rf_rd_row   (rf_rd_row),
        .rf_rd_ocid  (rf_rd_ocid),
        .rf_rd_slot  (rf_rd_slot),
        .rf_wr_en    (rf_wr_en),
        .rf_wr_row   (rf_wr_row),
        .bank_occ    (bank_occ)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int b = 0; b < 4; b++)
            exp_q[b].delete();
    endtask

    // Drive one request cycle; exp_rdy is the hand-derived acceptance.
    task automatic send(input logic ua, input logic [4:0] ra,
                        input logic ub, input logic [4:0] rb,
                        input logic [1:0] oc, input logic exp_rdy);
        req_valid = 1'b1;
        req_use_a = ua;
        req_use_b = ub;
        req_reg_a = ra;
        req_reg_b = rb;
        req_ocid  = oc;
        #2;
        chk("req_ready", {31'b0, req_ready}, {31'b0, exp_rdy});
        if (exp_rdy) begin
            if (ua) exp_q[ra[1:0]].push_back({ra[4:2], oc, 1'b0});
            if (ub) exp_q[rb[1:0]].push_back({rb[4:2], oc, 1'b1});
        end
        step();
        req_valid = 1'b0;
        req_use_a = 1'b0;
        req_use_b = 1'b0;
    endtask

    // Every writeback seen at a non-reset edge must strobe its bank next.
    always @(posedge clk) begin
        if (!rst && wb_en)
            wr_q.push_back({4'(1 << wb_reg[1:0]), wb_reg[4:2]});
    end

    always @(negedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (rf_rd_valid[b] === 1'b1) begin
                if (exp_q[b].size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rd_unexpected bank%0d: got row %0d ocid %0d slot %0d, required no read",
                             b, rf_rd_row[b*3 +: 3], rf_rd_ocid[b*2 +: 2], rf_rd_slot[b]);
                end else begin
                    e_rd = exp_q[b].pop_front();
                    chk($sformatf("rd_bank%0d", b),
                        {26'b0, rf_rd_row[b*3 +: 3], rf_rd_ocid[b*2 +: 2], rf_rd_slot[b]},
                        {26'b0, e_rd});
                end
            end
        end
        if (rf_wr_en !== 4'b0) begin
            if (wr_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL wr_unexpected: got mask %b row %0d, required no write",
                         rf_wr_en, rf_wr_row);
            end else begin
                e_wr = wr_q.pop_front();
                chk("wr", {25'b0, rf_wr_en, rf_wr_row}, {25'b0, e_wr});
            end
        end
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_use_a = 1'b0;
        req_use_b = 1'b0;
        req_reg_a = '0;
        req_reg_b = '0;
        req_ocid  = '0;
        flush     = 1'b0;
        wb_en     = 1'b0;
        wb_reg    = '0;
        step();
        step();
        rst = 1'b0;

        // reset state
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_rd_valid", {28'b0, rf_rd_valid}, 32'd0);
        chk("rst_wr_en", {28'b0, rf_wr_en}, 32'd0);
        chk("rst_occ", {20'b0, bank_occ}, 32'd0);

        // 1: r5 -> bank1 row1, r6 -> bank2 row1
        send(1, 5'd5, 1, 5'd6, 2'd2, 1);
        step();
        chk("t1_rd_valid", {28'b0, rf_rd_valid}, 32'b0110);
        step();
        chk("t1_idle", {28'b0, rf_rd_valid}, 32'd0);

        // 2: r4, r8 both bank0, A then B
        send(1, 5'd4, 1, 5'd8, 2'd1, 1);
        chk("t2_occ_peak", {29'b0, bank_occ[2:0]}, 32'd2);
        step();
        chk("t2_rd_a", {28'b0, rf_rd_valid}, 32'b0001);
        chk("t2_occ_1", {29'b0, bank_occ[2:0]}, 32'd1);
        step();
        chk("t2_rd_b", {28'b0, rf_rd_valid}, 32'b0001);
        chk("t2_occ_0", {29'b0, bank_occ[2:0]}, 32'd0);
        step();

        // 3: fill bank3 while writeback on r3 holds its port
        wb_en  = 1'b1;
        wb_reg = 5'd3;
        send(1, 5'd7,  0, 5'd0, 2'd0, 1);
        send(1, 5'd11, 0, 5'd0, 2'd1, 1);
        send(1, 5'd15, 0, 5'd0, 2'd2, 1);
        send(1, 5'd23, 1, 5'd27, 2'd3, 0);
        send(1, 5'd19, 0, 5'd0, 2'd3, 1);
        send(1, 5'd23, 0, 5'd0, 2'd0, 0);
        chk("t3_occ_full", {29'b0, bank_occ[11:9]}, 32'd4);
        chk("t3_wr_en", {28'b0, rf_wr_en}, 32'b1000);
        chk("t3_no_rd", {28'b0, rf_rd_valid}, 32'd0);
        wb_en = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("t3_drained", {29'b0, bank_occ[11:9]}, 32'd0);

        // 4: writeback steals the bank3 port from a queued read
        send(1, 5'd7, 0, 5'd0, 2'd3, 1);
        wb_en  = 1'b1;
        wb_reg = 5'd7;
        step();
        wb_en = 1'b0;
        chk("t4_wr_en", {28'b0, rf_wr_en}, 32'b1000);
        chk("t4_rd_stall", {28'b0, rf_rd_valid}, 32'd0);
        step();
        chk("t4_rd_late", {28'b0, rf_rd_valid}, 32'b1000);
        chk("t4_wr_off", {28'b0, rf_wr_en}, 32'd0);
        step();

        // 5: flush with 4 queued entries and a concurrent request
        wb_en  = 1'b1;
        wb_reg = 5'd3;
        send(1, 5'd3,  0, 5'd0, 2'd0, 1);
        send(1, 5'd7,  0, 5'd0, 2'd1, 1);
        send(1, 5'd11, 0, 5'd0, 2'd2, 1);
        send(1, 5'd15, 0, 5'd0, 2'd3, 1);
        chk("t5_occ_pre", {29'b0, bank_occ[11:9]}, 32'd4);
        flush = 1'b1;
        send(1, 5'd2, 0, 5'd0, 2'd1, 0);
        flush = 1'b0;
        clear_model();
        chk("t5_occ_clr", {20'b0, bank_occ}, 32'd0);
        chk("t5_no_rd", {28'b0, rf_rd_valid}, 32'd0);
        wb_en = 1'b0;
        step();
        chk("t5_no_rd2", {28'b0, rf_rd_valid}, 32'd0);
        step();

        // 6: wrap bank2 with ten back-to-back single reads
        for (int i = 0; i < 10; i++) begin
            logic [4:0] r;
            r = 5'(2 + 4 * (i % 8));
            send(1, r, 0, 5'd0, 2'(i % 4), 1);
        end
        for (int i = 0; i < 4; i++) step();
        chk("t6_occ", {29'b0, bank_occ[8:6]}, 32'd0);

        // 7: reset mid-operation discards queued reads
        send(1, 5'd0, 1, 5'd4, 2'd2, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_model();
        chk("t7_occ", {20'b0, bank_occ}, 32'd0);
        chk("t7_no_rd", {28'b0, rf_rd_valid}, 32'd0);
        chk("t7_ready", {31'b0, req_ready}, 32'd1);
        step();
        chk("t7_no_rd2", {28'b0, rf_rd_valid}, 32'd0);
        step();
        step();

        for (int b = 0; b < 4; b++)
            chk($sformatf("left_bank%0d", b), exp_q[b].size(), 32'd0);
        chk("left_wr", wr_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
